// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the bitcoin hashing subsystem: scheduler
// state encoding, memory geometry and the SHA-256 initial hash words.
package bitcoin_pkg;

  localparam int NUM_NONCES_DEFAULT = 16;
  localparam int MEM_ADDR_W         = 16;
  localparam int MEM_DATA_W         = 32;

  localparam logic [31:0] H0 = 32'h6a09e667;
  localparam logic [31:0] H1 = 32'hbb67ae85;
  localparam logic [31:0] H2 = 32'h3c6ef372;
  localparam logic [31:0] H3 = 32'ha54ff53a;
  localparam logic [31:0] H4 = 32'h510e527f;
  localparam logic [31:0] H5 = 32'h9b05688c;
  localparam logic [31:0] H6 = 32'h1f83d9ab;
  localparam logic [31:0] H7 = 32'h5be0cd19;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SCAN   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FINISH = 3'd5
  } sched_state_t;

endpackage

// File: rtl/nonce_batch_scheduler_if.sv
// Engine control and shared memory port seen by the nonce batch scheduler.
interface nonce_batch_scheduler_if;
  import bitcoin_pkg::*;

  // eng_start is a one-cycle launch pulse; eng_done is a level the engine
  // holds until the next eng_start. The memory port has no backpressure: a
  // registered mem_addr returns mem_read_data MEM_RD_LAT cycles later.
  logic                  eng_start;
  logic [31:0]           eng_message_addr;
  logic [31:0]           eng_output_addr;
  logic [31:0]           eng_nonce_base;
  logic                  eng_done;
  logic                  eng_mem_we;
  logic [MEM_ADDR_W-1:0] eng_mem_addr;
  logic [MEM_DATA_W-1:0] eng_mem_write_data;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [MEM_DATA_W-1:0] mem_write_data;
  logic [MEM_DATA_W-1:0] mem_read_data;

  modport master (
    output eng_start, eng_message_addr, eng_output_addr, eng_nonce_base,
    input  eng_done, eng_mem_we, eng_mem_addr, eng_mem_write_data,
    output mem_we, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  eng_start, eng_message_addr, eng_output_addr, eng_nonce_base,
    output eng_done, eng_mem_we, eng_mem_addr, eng_mem_write_data,
    input  mem_we, mem_addr, mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/result_scanner.sv
// Reads NUM_NONCES consecutive result words after a go pulse and flags each
// returned word that is strictly below the target.
module result_scanner
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEFAULT,
  parameter int MEM_RD_LAT = 2,
  localparam int IDX_W = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [MEM_ADDR_W-1:0] base_addr,
  input  logic [MEM_DATA_W-1:0] target,
  input  logic [MEM_DATA_W-1:0] rd_data,
  output logic [MEM_ADDR_W-1:0] rd_addr,
  output logic                  scan_done,
  output logic                  hit,
  output logic [IDX_W-1:0]      hit_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

  logic                  r_active;
  logic [IDX_W-1:0]      r_issue_cnt;
  logic [IDX_W-1:0]      r_rd_idx;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [MEM_RD_LAT-1:0] r_vld_sr;
  logic                  w_valid;

  assign w_valid   = r_vld_sr[MEM_RD_LAT-1];
  assign rd_addr   = r_addr;
  assign scan_done = w_valid && (r_rd_idx == LAST_IDX);
  assign hit       = w_valid && (rd_data < target);
  assign hit_index = r_rd_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active    <= 1'b0;
      r_issue_cnt <= '0;
      r_rd_idx    <= '0;
      r_addr      <= '0;
      r_vld_sr    <= '0;
    end else begin
      // The shift register tags which cycles carry returning read data.
      r_vld_sr <= (r_vld_sr << 1) | MEM_RD_LAT'(r_active);
      if (go) begin
        r_active    <= 1'b1;
        r_issue_cnt <= '0;
        r_rd_idx    <= '0;
        r_addr      <= base_addr;
      end else begin
        if (r_active) begin
          if (r_issue_cnt == LAST_IDX) begin
            r_active <= 1'b0;
          end else begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
            r_addr      <= r_addr + 1'b1;
          end
        end
        if (w_valid) begin
          r_rd_idx <= r_rd_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nonce_batch_scheduler.sv
// Runs one hash engine over consecutive nonce batches, scans each batch's
// results against a target and reports the first winning nonce.
module nonce_batch_scheduler
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEFAULT,
  parameter int MEM_RD_LAT = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [31:0]  message_addr,
  input  logic [31:0]  output_addr,
  input  logic [31:0]  nonce_start,
  input  logic [15:0]  max_batches,
  input  logic [31:0]  target,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         timeout_err,
  output logic [31:0]  found_nonce,
  output logic [15:0]  batches_run,
  output sched_state_t o_dbg_state,
  nonce_batch_scheduler_if.master bus
);

  localparam int IDX_W = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  sched_state_t    r_state;
  logic            r_done;
  logic            r_found;
  logic            r_timeout;
  logic            r_abort_pend;
  logic [31:0]     r_found_nonce;
  logic [15:0]     r_batches_run;
  logic [15:0]     r_max_batches;
  logic [31:0]     r_base;
  logic [31:0]     r_msg_addr;
  logic [31:0]     r_out_addr;
  logic [31:0]     r_target;
  logic [WD_W-1:0] r_wdog;

  logic                  w_busy;
  logic                  w_eng_owns_mem;
  logic                  w_scan_go;
  logic                  w_scan_done;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_hit_index;
  logic [MEM_ADDR_W-1:0] w_scan_addr;
  logic [15:0]           w_batches_next;

  assign w_busy = (r_state == ST_LAUNCH) || (r_state == ST_WAIT) ||
                  (r_state == ST_SCAN)   || (r_state == ST_NEXT);
  assign w_eng_owns_mem = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);
  assign w_scan_go      = (r_state == ST_WAIT) && bus.eng_done;
  assign w_batches_next = r_batches_run + 16'd1;

  assign busy        = w_busy;
  assign done        = r_done;
  assign found       = r_found;
  assign timeout_err = r_timeout;
  assign found_nonce = r_found_nonce;
  assign batches_run = r_batches_run;
  assign o_dbg_state = r_state;

  assign bus.eng_start        = (r_state == ST_LAUNCH);
  assign bus.eng_message_addr = r_msg_addr;
  assign bus.eng_output_addr  = r_out_addr;
  assign bus.eng_nonce_base   = r_base;

  // Ownership follows the registered state, so the switch to the scanner's
  // registered address happens on the WAIT->SCAN edge with no idle cycle.
  assign bus.mem_we         = w_eng_owns_mem ? bus.eng_mem_we : 1'b0;
  assign bus.mem_addr       = w_eng_owns_mem ? bus.eng_mem_addr : w_scan_addr;
  assign bus.mem_write_data = w_eng_owns_mem ? bus.eng_mem_write_data : '0;

  result_scanner #(
    .NUM_NONCES (NUM_NONCES),
    .MEM_RD_LAT (MEM_RD_LAT)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .go        (w_scan_go),
    .base_addr (r_out_addr[MEM_ADDR_W-1:0]),
    .target    (r_target),
    .rd_data   (bus.mem_read_data),
    .rd_addr   (w_scan_addr),
    .scan_done (w_scan_done),
    .hit       (w_hit),
    .hit_index (w_hit_index)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_timeout     <= 1'b0;
      r_abort_pend  <= 1'b0;
      r_found_nonce <= '0;
      r_batches_run <= '0;
      r_max_batches <= '0;
      r_base        <= '0;
      r_msg_addr    <= '0;
      r_out_addr    <= '0;
      r_target      <= '0;
      r_wdog        <= '0;
    end else begin
      if (w_busy && abort) begin
        r_abort_pend <= 1'b1;
      end
      // Later hits in the same batch are drained but never overwrite the first.
      if ((r_state == ST_SCAN) && w_hit && !r_found) begin
        r_found       <= 1'b1;
        r_found_nonce <= r_base + 32'(w_hit_index);
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_done        <= (max_batches == 16'd0);
            r_found       <= 1'b0;
            r_timeout     <= 1'b0;
            r_abort_pend  <= 1'b0;
            r_found_nonce <= '0;
            r_batches_run <= '0;
            r_max_batches <= max_batches;
            r_base        <= nonce_start;
            r_msg_addr    <= message_addr;
            r_out_addr    <= output_addr;
            r_target      <= target;
            r_state       <= (max_batches != 16'd0) ? ST_LAUNCH : ST_FINISH;
          end
        end
        ST_LAUNCH: begin
          r_wdog  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.eng_done) begin
            r_state <= ST_SCAN;
          end else if (r_wdog == WD_LAST) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= ST_FINISH;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_SCAN: begin
          if (w_scan_done) begin
            r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          r_batches_run <= w_batches_next;
          r_base        <= r_base + 32'(NUM_NONCES);
          if (r_found || (w_batches_next == r_max_batches) || r_abort_pend || abort) begin
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_state <= ST_LAUNCH;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
